// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the ADC frame unpacker and its consumers.
package adc_pkg;

    localparam int NUM_CH  = 64;
    localparam int WORD_W  = 16;
    localparam int FRAME_W = NUM_CH * WORD_W;
    localparam int CH_W    = $clog2(NUM_CH);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones. When an increment and a clear
// arrive together, the increment wins and the count restarts at 1.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            if (i_clr)
                r_cnt <= WIDTH'(1);
            else if (!(&r_cnt))
                r_cnt <= r_cnt + 1'b1;
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/adc_frame_unpacker.sv
// Holds a private copy of a 1024-bit ADC frame and streams it out as 64
// channel samples on a valid/ready interface, channel 0 = earliest bits.
module adc_frame_unpacker
    import adc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    input  logic               abort,
    input  logic               clr_status,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_last,
    output logic               busy,
    output logic               overrun,
    output logic [CNT_W-1:0]   overrun_cnt,
    output logic [15:0]        frame_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-1:0] r_held;
    logic [CH_W-1:0]    r_ch;
    logic [WORD_W-1:0]  r_data;
    logic               r_last;
    logic               r_overrun;
    logic [15:0]        r_frame_cnt;

    logic               w_xfer;
    logic               w_end;
    logic               w_accept;
    logic               w_drop;
    logic               w_advance;
    logic [CH_W-1:0]    w_ch_nxt;

    assign w_ch_nxt = r_ch + 1'b1;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_advance   = 1'b0;
        w_xfer      = (r_state == STREAM) && out_ready;
        w_end       = w_xfer && (r_ch == CH_W'(NUM_CH - 1));
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = STREAM;
                    end
                end
                STREAM: begin
                    if (w_end) begin
                        if (frame_valid)
                            w_accept = 1'b1;
                        else
                            w_state_nxt = IDLE;
                    end else begin
                        w_drop    = frame_valid;
                        w_advance = w_xfer;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: the wide holding register carries no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_held <= frame_in;
    end

    // Output word is registered from a channel-indexed mux, never by shifting r_held.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ch        <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ch        <= '0;
                r_data      <= frame_in[FRAME_W-1 -: WORD_W];
                r_last      <= (NUM_CH == 1);
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (w_advance) begin
                r_ch   <= w_ch_nxt;
                r_data <= r_held[FRAME_W - 1 - int'(w_ch_nxt) * WORD_W -: WORD_W];
                r_last <= (w_ch_nxt == CH_W'(NUM_CH - 1));
            end
            if (w_drop)
                r_overrun <= 1'b1;
            else if (clr_status)
                r_overrun <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_overrun_cnt (
        .clk   (clk),
        .rstb  (rstb),
        .i_inc (w_drop),
        .i_clr (clr_status),
        .o_cnt (overrun_cnt)
    );

    assign out_valid = (r_state == STREAM);
    assign busy      = (r_state == STREAM);
    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_last  = r_last;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_adc_frame_unpacker.sv
// Directed + randomized bench for adc_frame_unpacker, checked against a
// queue-based model of the sample stream and status counters.
module tb_adc_frame_unpacker;

    localparam int NUM_CH  = 64;
    localparam int WORD_W  = 16;
    localparam int FRAME_W = NUM_CH * WORD_W;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic [WORD_W-1:0] d;
        logic [5:0]        ch;
        logic              last;
    } samp_t;

    logic               clk;
    logic               rstb;
    logic [FRAME_W-1:0] frame_in;
    logic               frame_valid;
    logic               abort;
    logic               clr_status;
    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  out_data;
    logic [5:0]         out_ch;
    logic               out_last;
    logic               busy;
    logic               overrun;
    logic [CNT_W-1:0]   overrun_cnt;
    logic [15:0]        frame_cnt;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;

    samp_t q[$];
    int    m_frames = 0;
    bit    m_ov     = 0;
    int    m_cnt    = 0;

    adc_frame_unpacker #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .abort       (abort),
        .clr_status  (clr_status),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f;
        for (int i = 0; i < FRAME_W / 32; i++)
            f[i*32 +: 32] = $urandom();
        return f;
    endfunction

    function automatic logic [FRAME_W-1:0] ramp_frame();
        logic [FRAME_W-1:0] f;
        for (int k = 0; k < NUM_CH; k++)
            f[FRAME_W-1-k*WORD_W -: WORD_W] = 16'hA000 + 16'(k);
        return f;
    endfunction

    // Model: a frame becomes 64 queued samples; the queue head is what must be on the port.
    task automatic model_step(bit rdy, bit fv, bit ab, bit cl, logic [FRAME_W-1:0] f);
        bit was_stream;
        bit last_xfer;
        was_stream = (q.size() > 0);
        if (cl) begin
            m_ov  = 0;
            m_cnt = 0;
        end
        if (ab) begin
            q.delete();
            return;
        end
        last_xfer = was_stream && rdy && (q.size() == 1);
        if (was_stream && rdy)
            void'(q.pop_front());
        if (fv) begin
            if (!was_stream || last_xfer) begin
                for (int k = 0; k < NUM_CH; k++)
                    q.push_back('{f[FRAME_W-1-k*WORD_W -: WORD_W], 6'(k), (k == NUM_CH - 1)});
                m_frames = (m_frames + 1) % 65536;
            end else begin
                m_ov = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    endtask

    task automatic check_outputs(string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'(q.size() > 0));
        check({tag, ".busy"}, 64'(busy), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check({tag, ".data"}, 64'(out_data), 64'(q[0].d));
            check({tag, ".ch"}, 64'(out_ch), 64'(q[0].ch));
            check({tag, ".last"}, 64'(out_last), 64'(q[0].last));
        end
        check({tag, ".overrun"}, 64'(overrun), 64'(m_ov));
        check({tag, ".ovr_cnt"}, 64'(overrun_cnt), 64'(m_cnt));
        check({tag, ".frame_cnt"}, 64'(frame_cnt), 64'(m_frames));
    endtask

    // Drive at a falling edge, let one rising edge act, check at the next falling edge.
    task automatic cycle(string tag, bit rdy, bit fv, bit ab, bit cl, logic [FRAME_W-1:0] f);
        out_ready   = rdy;
        frame_valid = fv;
        abort       = ab;
        clr_status  = cl;
        frame_in    = f;
        model_step(rdy, fv, ab, cl, f);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [FRAME_W-1:0] fa;
        int vcnt;
        int start_frames;

        rstb        = 1'b0;
        out_ready   = 1'b0;
        frame_valid = 1'b0;
        abort       = 1'b0;
        clr_status  = 1'b0;
        frame_in    = '0;

        repeat (2) @(negedge clk);
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.data", 64'(out_data), 64'd0);
        check("rst.ch", 64'(out_ch), 64'd0);
        check("rst.last", 64'(out_last), 64'd0);
        check_outputs("rst");
        rstb = 1'b1;
        @(negedge clk);

        // Ramp frame, ready always high: 64 transfers then idle.
        cycle("ramp", 1, 1, 0, 0, ramp_frame());
        check("ramp.first", 64'(out_data), 64'h0000_0000_0000_A000);
        for (int i = 0; i < NUM_CH; i++)
            cycle("ramp", 1, 0, 0, 0, '0);
        check("ramp.frames", 64'(frame_cnt), 64'd1);
        check("ramp.idle", 64'(busy), 64'd0);

        // Random frame with random backpressure.
        cycle("stall", 1'($urandom_range(0, 1)), 1, 0, 0, rand_frame());
        for (int i = 0; i < 1000 && q.size() > 0; i++)
            cycle("stall", 1'($urandom_range(0, 1)), 0, 0, 0, '0);
        check("stall.drained", 64'(out_valid), 64'd0);

        // Back-to-back: second frame strobed in the ch63 transfer cycle.
        start_frames = m_frames;
        vcnt = 0;
        cycle("b2b", 1, 1, 0, 0, rand_frame());
        vcnt += int'(out_valid);
        for (int i = 0; i < NUM_CH - 1; i++) begin
            cycle("b2b", 1, 0, 0, 0, '0);
            vcnt += int'(out_valid);
        end
        check("b2b.at_last", 64'(out_last), 64'd1);
        cycle("b2b", 1, 1, 0, 0, rand_frame());
        vcnt += int'(out_valid);
        for (int i = 0; i < NUM_CH - 1; i++) begin
            cycle("b2b", 1, 0, 0, 0, '0);
            vcnt += int'(out_valid);
        end
        check("b2b.gapless", 64'(vcnt), 64'd128);
        cycle("b2b", 1, 0, 0, 0, '0);
        check("b2b.frames", 64'(frame_cnt), 64'(start_frames + 2));
        check("b2b.overrun", 64'(overrun), 64'd0);

        // Drops at ch10 and ch40 while the held frame keeps streaming.
        cycle("drop", 1, 1, 0, 0, rand_frame());
        for (int i = 0; i < 100 && q.size() > 0; i++) begin
            if (q[0].ch == 6'd10 || q[0].ch == 6'd40)
                cycle("drop", 1, 1, 0, 0, rand_frame());
            else
                cycle("drop", 1, 0, 0, 0, '0);
        end
        check("drop.overrun", 64'(overrun), 64'd1);
        check("drop.cnt", 64'(overrun_cnt), 64'd2);
        cycle("clr", 0, 0, 0, 1, '0);
        check("clr.overrun", 64'(overrun), 64'd0);
        check("clr.cnt", 64'(overrun_cnt), 64'd0);

        // Saturation, then a clear coinciding with a drop.
        cycle("sat", 0, 1, 0, 0, rand_frame());
        for (int i = 0; i < 300; i++)
            cycle("sat", 0, 1, 0, 0, rand_frame());
        check("sat.cnt", 64'(overrun_cnt), 64'hFF);
        cycle("sat_clr", 0, 1, 0, 1, rand_frame());
        check("sat_clr.overrun", 64'(overrun), 64'd1);
        check("sat_clr.cnt", 64'(overrun_cnt), 64'd1);
        for (int i = 0; i < 100 && q.size() > 0; i++)
            cycle("sat", 1, 0, 0, 0, '0);
        cycle("sat", 0, 0, 0, 1, '0);

        // Abort at ch20 with a coincident frame_valid.
        cycle("abort", 1, 1, 0, 0, rand_frame());
        for (int i = 0; i < 20; i++)
            cycle("abort", 1, 0, 0, 0, '0);
        check("abort.at_ch", 64'(out_ch), 64'd20);
        cycle("abort", 1, 1, 1, 0, rand_frame());
        check("abort.valid", 64'(out_valid), 64'd0);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.overrun", 64'(overrun), 64'd0);
        cycle("abort_idle", 1, 1, 1, 0, rand_frame());
        fa = rand_frame();
        cycle("restart", 1, 1, 0, 0, fa);
        check("restart.ch", 64'(out_ch), 64'd0);
        check("restart.data", 64'(out_data), 64'(fa[FRAME_W-1 -: WORD_W]));
        for (int i = 0; i < 10; i++)
            cycle("restart", 1, 0, 0, 0, '0);

        // Asynchronous reset mid-stream: outputs clear without a clock edge.
        out_ready   = 1'b1;
        frame_valid = 1'b0;
        #2;
        rstb = 1'b0;
        #1;
        q.delete();
        m_frames = 0;
        m_ov     = 0;
        m_cnt    = 0;
        check("arst.data", 64'(out_data), 64'd0);
        check("arst.ch", 64'(out_ch), 64'd0);
        check("arst.last", 64'(out_last), 64'd0);
        check_outputs("arst");
        @(negedge clk);
        rstb = 1'b1;
        cycle("post_rst", 1, 0, 0, 0, '0);
        cycle("post_rst", 1, 1, 0, 0, rand_frame());
        for (int i = 0; i < 100 && q.size() > 0; i++)
            cycle("post_rst", 1'($urandom_range(0, 1)), 0, 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_frame_unpacker.md
# adc_frame_unpacker

Splits each captured 1024-bit ADC frame into 64 sequential 16-bit channel samples. Each sample goes out on a valid/ready stream tagged with its channel index and an end-of-frame marker. Sits directly downstream of the double-buffered frame capture register and feeds per-channel feature extraction / HDC encoding. Holds a private copy of the frame, so the capture register may be overwritten by the next packet while streaming continues.

## Interface
Parameters:
- NUM_CH, 64, channels per frame
- WORD_W, 16, bits per channel sample
- FRAME_W, NUM_CH*WORD_W (1024), frame width; derived, not overridden
- CNT_W, 8, width of the saturating overrun counter

Ports:
- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- frame_in  in  FRAME_W  captured frame; first-received bit at FRAME_W-1
- frame_valid  in  1  single-cycle strobe; frame_in is valid in this cycle
- abort  in  1  synchronous; drop the current frame and return to idle
- clr_status  in  1  synchronous; clear overrun flag and counter
- out_valid  out  1  sample valid
- out_ready  in  1  consumer accepts sample
- out_data  out  WORD_W  sample
- out_ch  out  $clog2(NUM_CH)  channel index of out_data
- out_last  out  1  high with channel NUM_CH-1
- busy  out  1  frame held / streaming
- overrun  out  1  sticky; a frame was dropped
- overrun_cnt  out  CNT_W  dropped frames, saturating at all-ones
- frame_cnt  out  16  accepted frames, wraps modulo 2^16

## Operation
- Reset: all outputs are 0, and the state is IDLE.
- States:
  - IDLE: out_valid=0, busy=0.
  - STREAM: busy=1; out_valid=1 unless abort.
- Channel mapping: channel k = held[FRAME_W-1-k*WORD_W -: WORD_W]. Channel 0 holds the earliest-received bits.
- IDLE + frame_valid:
  - latch frame_in into the holding register
  - set ch=0
  - increment frame_cnt
  - go to STREAM
- STREAM, transfer (out_valid && out_ready):
  - if ch < NUM_CH-1: ch+1
  - if ch == NUM_CH-1: go to IDLE, unless a frame is accepted in the same cycle (see below)
- Back-to-back accept: frame_valid in the same cycle as the last-word transfer is accepted. The frame is latched, ch=0, the state stays STREAM, and frame_cnt increments.
- Any other frame_valid while in STREAM is dropped. The held frame is untouched, overrun is set to 1, and overrun_cnt increments, saturating.
- out_data, out_ch and out_last stay stable while out_valid && !out_ready.
- abort has priority over everything:
  - next state IDLE, out_valid=0
  - a frame_valid in the same cycle is discarded without counting as overrun
  - abort is ignored in IDLE apart from that discard
- clr_status clears overrun/overrun_cnt. If it coincides with a drop, the drop wins: overrun=1 and cnt=1.
- Reset mid-stream: all outputs are 0 immediately (asynchronous); the partial frame is lost.

## Timing
- All outputs are registered.
- frame_valid at edge N: out_valid=1 with ch0 after edge N. That is one cycle of latency.
- With out_ready held high, a frame streams in exactly NUM_CH cycles, and out_last is high on the last of them.
- Back-to-back frames give continuous out_valid, with no bubble between ch63 and the next ch0.
- out_ready may be deasserted at any time. There is no combinational path from out_ready to out_valid.
- Upstream contract: frame_valid arrives one cycle after the capture register updates. The top level delays pkt_done by one flop to produce it.

## Structure
- Shared package adc_pkg holds NUM_CH, WORD_W, FRAME_W, CH_W=$clog2(NUM_CH), and the state enum {IDLE, STREAM}.
- One natural sub-module: sat_counter (parameter width, inc, clr; holds at all-ones). It provides overrun_cnt and is reusable for other error counters.
- Word select is a mux on ch over the holding register. Do not use a 1024-bit shift, to keep toggle power low.

## Test plan
- Reset, then frame of channel k = 16'hA000+k with out_ready=1 → 64 transfers, ch 0..63, data A000..A03F in order, out_last only on ch63, frame_cnt=1, busy low after the last transfer.
- out_ready toggled pseudo-randomly (≈50%) → identical data sequence; out_data and out_ch stable across every stall cycle.
- Two frames, the second strobed in the ch63 transfer cycle → 128 consecutive out_valid cycles with no gap; frame_cnt=2; overrun=0.
- frame_valid pulsed at ch10 and again at ch40 (ready=1) → the original frame completes unchanged; overrun=1, overrun_cnt=2. Then clr_status → both 0.
- 300 dropped frames → overrun_cnt saturates at 8'hFF.
- abort at ch20 together with frame_valid → out_valid=0 next cycle, busy=0, no overrun. A fresh frame_valid afterwards restarts at ch0. rstb pulsed mid-stream → all outputs 0 asynchronously.
